// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: buffers two previous lines and emits a full
// neighbourhood (c1..c9, row-major, c9 newest) for every interior pixel.
module window3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic [DATA_W-1:0] c6,
    output logic [DATA_W-1:0] c7,
    output logic [DATA_W-1:0] c8,
    output logic [DATA_W-1:0] c9,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] top_h [2];
    logic [DATA_W-1:0] mid_h [2];
    logic [DATA_W-1:0] bot_h [2];
    logic              emit;
    logic              last_pixel;

    assign rd1        = lb1[col];
    assign rd2        = lb2[col];
    assign emit       = in_valid && (row >= RW'(2)) && (col >= CW'(2));
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

    // Line buffers need no reset: a window is only emitted once two lines of
    // the current frame have been written over whatever was there before.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2[col] <= rd1;
            lb1[col] <= in_pixel;
        end
    end

    // The oldest window column moves straight into c1/c4/c7, so only the two
    // newer columns are kept as history; the incoming column comes from the
    // line-buffer reads and the pixel itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                top_h[i] <= '0;
                mid_h[i] <= '0;
                bot_h[i] <= '0;
            end
            c1 <= '0; c2 <= '0; c3 <= '0;
            c4 <= '0; c5 <= '0; c6 <= '0;
            c7 <= '0; c8 <= '0; c9 <= '0;
        end else begin
            out_valid  <= emit;
            frame_done <= emit && last_pixel;
            if (in_valid) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                top_h[0] <= top_h[1];
                top_h[1] <= rd2;
                mid_h[0] <= mid_h[1];
                mid_h[1] <= rd1;
                bot_h[0] <= bot_h[1];
                bot_h[1] <= in_pixel;
            end
            if (emit) begin
                c1 <= top_h[0]; c2 <= top_h[1]; c3 <= rd2;
                c4 <= mid_h[0]; c5 <= mid_h[1]; c6 <= rd1;
                c7 <= bot_h[0]; c8 <= bot_h[1]; c9 <= in_pixel;
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen: a 4x4 instance for directed frame
// scenarios and a 64x64 instance for a full ramp frame.
module tb_window3x3_gen;

    typedef struct {
        logic [71:0] win;
        logic        fd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sValid = 1'b0;
    logic [7:0]  sPixel = '0;
    logic        sOutValid, sFrameDone;
    logic [7:0]  s1, s2, s3, s4, s5, s6, s7, s8, s9;
    logic [71:0] sWin;

    logic        bValid = 1'b0;
    logic [7:0]  bPixel = '0;
    logic        bOutValid, bFrameDone;
    logic [7:0]  b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic [71:0] bWin;

    assign sWin = {s1, s2, s3, s4, s5, s6, s7, s8, s9};
    assign bWin = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

    window3x3_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(sValid), .in_pixel(sPixel),
        .out_valid(sOutValid),
        .c1(s1), .c2(s2), .c3(s3), .c4(s4), .c5(s5), .c6(s6), .c7(s7), .c8(s8), .c9(s9),
        .frame_done(sFrameDone)
    );

    window3x3_gen #(.DATA_W(8), .IMG_W(64), .IMG_H(64)) dutBig (
        .clk(clk), .rst(rst), .in_valid(bValid), .in_pixel(bPixel),
        .out_valid(bOutValid),
        .c1(b1), .c2(b2), .c3(b3), .c4(b4), .c5(b5), .c6(b6), .c7(b7), .c8(b8), .c9(b9),
        .frame_done(bFrameDone)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    int          cyc         = 0;
    exp_t        sQ[$];
    exp_t        bQ[$];
    logic [71:0] sLog[$];
    logic [71:0] holdRef = '0;
    int          sFdCount = 0;
    int          bFdCount = 0;
    int          bWinCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(string name, logic [79:0] act, logic [79:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    function automatic void checkLog(string name, int idx, logic [71:0] req);
        if (idx >= sLog.size()) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s: window %0d never emitted, required %h", name, idx, req);
        end else begin
            checkOutput(name, {8'h0, sLog[idx]}, {8'h0, req});
        end
    endfunction

    // Reference window from raster index p of a frame whose pixel i = base+i.
    function automatic logic [71:0] expWindow(int base, int p, int w);
        logic [71:0] win;
        int topLeft;
        win = '0;
        topLeft = p - 2 * w - 2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win[(8 - (r * 3 + c)) * 8 +: 8] = 8'((base + topLeft + r * w + c) & 255);
        return win;
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int base, input int p);
        exp_t e;
        if ((p / 4) >= 2 && (p % 4) >= 2) begin
            e.win = expWindow(base, p, 4);
            e.fd  = (p == 15);
            e.cyc = cyc + 1;
            sQ.push_back(e);
        end
        sValid = 1'b1;
        sPixel = 8'((base + p) & 255);
        @(posedge clk);
        #1;
        sValid = 1'b0;
    endtask

    task automatic applyStimulusBig(input int p);
        exp_t e;
        if ((p / 64) >= 2 && (p % 64) >= 2) begin
            e.win = expWindow(0, p, 64);
            e.fd  = (p == 4095);
            e.cyc = cyc + 1;
            bQ.push_back(e);
        end
        bValid = 1'b1;
        bPixel = 8'(p & 255);
        @(posedge clk);
        #1;
        bValid = 1'b0;
    endtask

    task automatic sendFrame(input int base, input bit gapped);
        for (int p = 0; p < 16; p++) begin
            if (gapped) idleCycles($urandom_range(0, 3));
            applyStimulus(base, p);
        end
    endtask

    // Small-instance monitor: pops on every window, otherwise checks that the
    // taps hold the last expected window and no expected window went missing.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset_outputs", {6'h0, sOutValid, sFrameDone, sWin}, 80'h0);
            holdRef = '0;
        end else if (sOutValid) begin
            if (sQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_window: actual %h required none", sWin);
            end else begin
                exp_t e;
                e = sQ.pop_front();
                checkOutput("window", {8'h0, sWin}, {8'h0, e.win});
                checkOutput("frame_done", {79'h0, sFrameDone}, {79'h0, e.fd});
                checkOutput("latency", 80'(cyc), 80'(e.cyc));
                holdRef = e.win;
                sLog.push_back(sWin);
                if (sFrameDone) sFdCount++;
            end
        end else begin
            checkOutput("hold", {8'h0, sWin}, {8'h0, holdRef});
            checkOutput("frame_done_idle", {79'h0, sFrameDone}, 80'h0);
            if (sQ.size() > 0 && sQ[0].cyc <= cyc) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL missing_window: actual none required %h", sQ[0].win);
                void'(sQ.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bOutValid) begin
            if (bQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL big_unexpected_window: actual %h required none", bWin);
            end else begin
                exp_t e;
                e = bQ.pop_front();
                checkOutput("big_window", {8'h0, bWin}, {8'h0, e.win});
                checkOutput("big_frame_done", {79'h0, bFrameDone}, {79'h0, e.fd});
                checkOutput("big_latency", 80'(cyc), 80'(e.cyc));
                bWinCount++;
                if (bFrameDone) bFdCount++;
            end
        end else if (!rst && bQ.size() > 0 && bQ[0].cyc <= cyc) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL big_missing_window: actual none required %h", bQ[0].win);
            void'(bQ.pop_front());
        end
    end

    initial begin
        int n0;
        int fd0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] basic frame and line-wrap suppression");
        n0 = sLog.size();
        for (int p = 0; p < 16; p++) begin
            applyStimulus(0, p);
            if (p == 13)
                checkOutput("hold_between", {8'h0, sWin}, {8'h0, 72'h01_02_03_05_06_07_09_0A_0B});
        end
        idleCycles(3);
        checkLog("basic_first", n0, 72'h00_01_02_04_05_06_08_09_0A);
        checkLog("basic_last", n0 + 3, 72'h05_06_07_09_0A_0B_0D_0E_0F);
        checkOutput("basic_count", 80'(sLog.size() - n0), 80'd4);

        $display("[TB] gapped frame");
        n0 = sLog.size();
        sendFrame(0, 1'b1);
        idleCycles(3);
        checkLog("gapped_first", n0, 72'h00_01_02_04_05_06_08_09_0A);
        checkLog("gapped_last", n0 + 3, 72'h05_06_07_09_0A_0B_0D_0E_0F);

        $display("[TB] back-to-back frames");
        n0 = sLog.size();
        fd0 = sFdCount;
        sendFrame(0, 1'b0);
        sendFrame(100, 1'b0);
        idleCycles(3);
        checkLog("b2b_second_first", n0 + 4, 72'h64_65_66_68_69_6A_6C_6D_6E);
        checkOutput("b2b_frame_done", 80'(sFdCount - fd0), 80'd2);

        $display("[TB] reset mid-frame");
        for (int p = 0; p < 7; p++) applyStimulus(0, p);
        #2 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        n0 = sLog.size();
        sendFrame(50, 1'b0);
        idleCycles(3);
        checkLog("reset_first", n0, 72'h32_33_34_36_37_38_3A_3B_3C);
        checkOutput("reset_count", 80'(sLog.size() - n0), 80'd4);
        checkOutput("small_queue_drained", 80'(sQ.size()), 80'd0);

        $display("[TB] 64x64 ramp frame");
        for (int p = 0; p < 4096; p++) applyStimulusBig(p);
        idleCycles(3);
        checkOutput("big_window_count", 80'(bWinCount), 80'd3844);
        checkOutput("big_frame_done_count", 80'(bFdCount), 80'd1);
        checkOutput("big_queue_drained", 80'(bQ.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
